// File: rtl/euclid_distance_unit.sv
// Euclidean distance accelerator: floor(sqrt(sum_i (A[i]-B[i])^2)) over two
// host-loaded vector banks, using a difference/square/accumulate pipeline
// followed by a restoring bit-serial square root.
module euclid_distance_unit #(
    parameter int VARWIDTH = 32,
    parameter int VECWIDTH = 10,
    localparam int ADDW     = (VECWIDTH > 1) ? $clog2(VECWIDTH) : 1,
    localparam int ACCWIDTH = 2 * VARWIDTH + $clog2(VECWIDTH + 1),
    localparam int OUTWIDTH = (ACCWIDTH + 1) / 2
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                STARTCALC,
    input  logic                WE,
    input  logic                WSEL,
    input  logic [ADDW-1:0]     WADDR,
    input  logic [VARWIDTH-1:0] WDATA,
    output logic                BUSY,
    output logic                RDY,
    output logic [OUTWIDTH-1:0] OUTVAL
);

    localparam int RADW    = 2 * OUTWIDTH;      // radicand padded to an even width
    localparam int REMW    = OUTWIDTH + 3;      // partial remainder plus two shifted-in bits
    localparam int CNT_MAX = (VECWIDTH > OUTWIDTH) ? ((VECWIDTH > 4) ? VECWIDTH : 4)
                                                   : ((OUTWIDTH > 4) ? OUTWIDTH : 4);
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [ADDW:0] VEC_LIMIT = ADDW'(VECWIDTH - 1) + (ADDW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_SQRT
    } state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [ADDW-1:0]       addr_q, addr_d;
    logic [ACCWIDTH-1:0]   acc_q, acc_d;
    logic [RADW-1:0]       rad_q, rad_d;
    logic [REMW-1:0]       rem_q, rem_d;
    logic [OUTWIDTH-1:0]   root_q, root_d;
    logic                  rdy_q, rdy_d;
    logic [OUTWIDTH-1:0]   outval_q, outval_d;

    logic                  v1_q, v2_q, v3_q;
    logic [VARWIDTH-1:0]   diff_q;
    logic [2*VARWIDTH-1:0] sq_q;

    logic                  wr_ok;
    logic                  streaming;
    logic [REMW-1:0]       rem_shift;
    logic [REMW-1:0]       trial;
    logic [REMW-1:0]       rem_n;
    logic [OUTWIDTH-1:0]   root_n;

    assign streaming = (state_q == S_STREAM);

    // Host writes land only while idle, in range, and not under reset.
    assign wr_ok = WE && !RST && (state_q == S_IDLE) && ({1'b0, WADDR} < VEC_LIMIT);

    // Two vector banks (A = 0, B = 1), each with a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [VARWIDTH-1:0] mem [VECWIDTH];
            logic [VARWIDTH-1:0] rd_q;

            // Synchronous write from the host, registered read while streaming.
            always_ff @(posedge clk) begin
                if (wr_ok && (WSEL == 1'(gi))) begin
                    mem[WADDR] <= WDATA;
                end
                if (streaming) begin
                    rd_q <= mem[addr_q];
                end
            end
        end
    endgenerate

    // Difference and square stages; valid bits track elements through the pipe.
    always_ff @(posedge clk) begin
        if (RST) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= streaming;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
        diff_q <= (g_bank[0].rd_q >= g_bank[1].rd_q) ? (g_bank[0].rd_q - g_bank[1].rd_q)
                                                     : (g_bank[1].rd_q - g_bank[0].rd_q);
        sq_q   <= (2*VARWIDTH)'(diff_q) * (2*VARWIDTH)'(diff_q);
    end

    // One restoring square-root step: bring down two radicand bits, try (4*root+1).
    always_comb begin
        rem_shift = {rem_q[REMW-3:0], rad_q[RADW-1 -: 2]};
        trial     = {1'b0, root_q, 2'b01};
        if (rem_shift >= trial) begin
            rem_n  = rem_shift - trial;
            root_n = {root_q[OUTWIDTH-2:0], 1'b1};
        end else begin
            rem_n  = rem_shift;
            root_n = {root_q[OUTWIDTH-2:0], 1'b0};
        end
    end

    // Controller next-state, accumulator and square-root sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        rdy_d    = rdy_q;
        outval_d = outval_q;

        if (v3_q) begin
            acc_d = acc_q + ACCWIDTH'(sq_q);
        end

        case (state_q)
            S_IDLE: begin
                if (STARTCALC) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            S_STREAM: begin
                addr_d = addr_q + ADDW'(1);
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(VECWIDTH - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNTW'(1);
                // Last element reaches the accumulator on the third drain edge.
                if (cnt_q == CNTW'(3)) begin
                    state_d = S_SQRT;
                    cnt_d   = '0;
                    rad_d   = RADW'(acc_q);
                    rem_d   = '0;
                    root_d  = '0;
                end
            end
            S_SQRT: begin
                rem_d  = rem_n;
                root_d = root_n;
                rad_d  = rad_q << 2;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(OUTWIDTH - 1)) begin
                    state_d  = S_IDLE;
                    rdy_d    = 1'b1;
                    outval_d = root_n;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            acc_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            rdy_q    <= 1'b0;
            outval_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            rdy_q    <= rdy_d;
            outval_q <= outval_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign RDY    = rdy_q;
    assign OUTVAL = outval_q;

endmodule

// File: tb/tb_euclid_distance_unit.sv
// Directed bench for euclid_distance_unit with default parameters
// (VECWIDTH=10, OUTWIDTH=34, fixed latency 48 edges).
module tb_euclid_distance_unit;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        STARTCALC = 1'b0;
    logic        WE = 1'b0;
    logic        WSEL = 1'b0;
    logic [3:0]  WADDR = '0;
    logic [31:0] WDATA = '0;
    logic        BUSY;
    logic        RDY;
    logic [33:0] OUTVAL;

    int n_checks = 0;
    int n_fail   = 0;

    euclid_distance_unit dut (
        .clk       (clk),
        .RST       (RST),
        .STARTCALC (STARTCALC),
        .WE        (WE),
        .WSEL      (WSEL),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .BUSY      (BUSY),
        .RDY       (RDY),
        .OUTVAL    (OUTVAL)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] data);
        WE = 1'b1;
        WSEL = sel;
        WADDR = addr;
        WDATA = data;
        tick();
        WE = 1'b0;
    endtask

    task automatic fill(input logic sel, input logic [31:0] data);
        for (int i = 0; i < 10; i++) wr(sel, 4'(i), data);
    endtask

    // mode 0: plain run; 1: blocked writes at S+5 and S+20;
    // 2: reset at S+30; 3: write A[1]=8 on the start edge.
    task automatic run(input logic [33:0] exp, input int mode, input string tag);
        logic [33:0] old;
        int lat;
        bit busy_ok;
        bit hold_ok;
        old = OUTVAL;
        STARTCALC = 1'b1;
        if (mode == 3) begin
            WE = 1'b1; WSEL = 1'b0; WADDR = 4'd1; WDATA = 32'd8;
        end
        tick();
        STARTCALC = 1'b0;
        WE = 1'b0;
        check({tag, "_busy_at_S"}, BUSY, 1);
        check({tag, "_rdy_at_S"}, RDY, 0);
        lat = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (RDY !== 1'b1 && lat < 200) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            if (OUTVAL !== old) hold_ok = 1'b0;
            if (mode == 1 && lat == 4) begin
                WE = 1'b1; WSEL = 1'b0; WADDR = 4'd0; WDATA = 32'd500;
            end else if (mode == 1 && lat == 19) begin
                WE = 1'b1; WSEL = 1'b1; WADDR = 4'd3; WDATA = 32'd999;
            end else begin
                WE = 1'b0;
            end
            if (mode == 2 && lat == 29) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                check({tag, "_rst_busy"}, BUSY, 0);
                check({tag, "_rst_rdy"}, RDY, 0);
                check({tag, "_rst_outval"}, OUTVAL, 0);
                return;
            end
            tick();
            lat++;
        end
        WE = 1'b0;
        $display("run %s: latency %0d outval %0d", tag, lat, OUTVAL);
        check({tag, "_latency"}, lat, 48);
        check({tag, "_busy_during"}, busy_ok, 1);
        check({tag, "_outval_hold"}, hold_ok, 1);
        check({tag, "_busy_done"}, BUSY, 0);
        check({tag, "_outval"}, OUTVAL, exp);
    endtask

    initial begin
        int lat;
        // Bring-up reset, then load A={3,4,0,...}, B=0.
        tick();
        tick();
        RST = 1'b0;
        fill(0, 32'd0);
        fill(1, 32'd0);
        wr(0, 4'd0, 32'd3);
        wr(0, 4'd1, 32'd4);

        // 1. Reset with STARTCALC and WE held high: nothing starts, nothing written.
        RST = 1'b1; STARTCALC = 1'b1;
        WE = 1'b1; WSEL = 1'b0; WADDR = 4'd0; WDATA = 32'd77;
        tick();
        tick();
        check("reset_busy", BUSY, 0);
        check("reset_rdy", RDY, 0);
        check("reset_outval", OUTVAL, 0);
        RST = 1'b0; STARTCALC = 1'b0; WE = 1'b0;
        tick();
        check("post_reset_idle", BUSY, 0);

        // 2. 3-4-5 triangle (A[0] still 3 proves the reset-time write was dropped).
        run(34'd5, 0, "t345");

        // 3. Absolute difference and symmetry.
        fill(0, 32'd0);
        fill(1, 32'd1000);
        run(34'd3162, 0, "a_lt_b");
        fill(0, 32'd1000);
        fill(1, 32'd0);
        run(34'd3162, 0, "a_gt_b");
        for (int i = 0; i < 10; i++) begin
            wr(0, 4'(i), 32'd12345 * 32'(i) + 32'd7);
            wr(1, 4'(i), 32'd12345 * 32'(i) + 32'd7);
        end
        run(34'd0, 0, "equal");
        fill(0, 32'd0);
        fill(1, 32'd0);
        wr(0, 4'd0, 32'hFFFF_FFFF);
        run(34'd4294967295, 0, "max_a");
        wr(0, 4'd0, 32'd0);
        wr(1, 4'd0, 32'hFFFF_FFFF);
        run(34'd4294967295, 0, "max_b");

        // 4. A={1..10}, B=0 -> sum 385.
        fill(1, 32'd0);
        for (int i = 0; i < 10; i++) wr(0, 4'(i), 32'(i + 1));
        run(34'd19, 0, "ramp");

        // 5. Writes while busy and out-of-range writes are dropped.
        run(34'd19, 1, "busy_writes");
        run(34'd19, 0, "after_busy_writes");
        wr(0, 4'd12, 32'd9999);
        run(34'd19, 0, "addr_oob");

        // 6. Reset mid-run, then {6,8} with A[1] written on the start edge.
        run(34'd0, 2, "abort");
        fill(0, 32'd0);
        wr(0, 4'd0, 32'd6);
        run(34'd10, 3, "restart");

        // Back-to-back with STARTCALC held high.
        STARTCALC = 1'b1;
        tick();
        check("b2b_first_busy", BUSY, 1);
        lat = 0;
        while (RDY !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("b2b_first_latency", lat, 48);
        check("b2b_first_outval", OUTVAL, 10);
        tick();
        check("b2b_rdy_one_cycle", RDY, 0);
        check("b2b_second_busy", BUSY, 1);
        lat = 0;
        while (RDY !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        STARTCALC = 1'b0;
        check("b2b_second_latency", lat, 48);
        check("b2b_second_outval", OUTVAL, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/euclid_distance_unit.md
# euclid_distance_unit

- Computes the integer Euclidean distance floor(sqrt(sum_i (A[i]-B[i])^2)) between two VECWIDTH-element unsigned vectors.
- Contains:
  - two internal vector banks (A and B), written by the host;
  - a sequencing controller;
  - a 3-stage difference/square pipeline;
  - an accumulator;
  - a bit-serial integer square root.
- Sits beside the host as a distance accelerator. The host loads both vectors, pulses STARTCALC, and waits for RDY.

## Interface
One clock; reset is synchronous and active-high.
Parameters:
- VARWIDTH, 32, element width (unsigned).
- VECWIDTH, 10, elements per vector (≥1).
- Derived:
  - ADDW = max(1, clog2(VECWIDTH));
  - ACCWIDTH = 2*VARWIDTH + clog2(VECWIDTH+1);
  - OUTWIDTH = ceil(ACCWIDTH/2). Defaults: ACCWIDTH=68, OUTWIDTH=34.

Ports:
- clk  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- STARTCALC  in  1  start request, sampled at the edge.
- WE  in  1  element write enable.
- WSEL  in  1  bank select: 0 = A, 1 = B.
- WADDR  in  ADDW  element index.
- WDATA  in  VARWIDTH  element value.
- BUSY  out  1  high while a calculation is in progress.
- RDY  out  1  result valid.
- OUTVAL  out  OUTWIDTH  distance result.

## Operation
- Banks:
  - Each bank is VECWIDTH x VARWIDTH, with a synchronous write and a registered read (1-cycle read latency).
  - RST does not clear bank contents.
- Writes:
  - Accepted only when WE=1, BUSY=0 and WADDR<VECWIDTH. All other writes are dropped silently.
  - A write and an accepted STARTCALC on the same edge: the write commits, and the calculation uses the new value.
- FSM states:
  - IDLE → STREAM on STARTCALC=1.
  - STREAM, VECWIDTH cycles: issues addresses 0..VECWIDTH-1, one per cycle, to both banks.
  - DRAIN, 4 cycles: empties the pipeline.
  - SQRT, OUTWIDTH cycles: computes the root.
  - SQRT then returns to IDLE with RDY=1.
- Start acceptance:
  - STARTCALC is ignored outside IDLE.
  - An accepted start clears the accumulator and clears RDY on the same edge.
- Pipeline:
  - Stage 1: read data registered.
  - Stage 2: |A-B|, VARWIDTH bits, unsigned absolute difference.
  - Stage 3: square, 2*VARWIDTH bits.
  - Stage 4: accumulate into ACCWIDTH bits. This width cannot overflow.
- Square root:
  - Restoring bit-serial method, one result bit per cycle, MSB first, over OUTWIDTH cycles.
  - Result is floor(sqrt(acc)), exact for every acc.
- Output hold:
  - OUTVAL and RDY hold until the next accepted start or RST.
  - OUTVAL keeps its old value while BUSY; it updates only on the edge that sets RDY.
- Reset values: BUSY=0, RDY=0, OUTVAL=0, FSM=IDLE, accumulator=0.
- Reset mid-operation: the calculation is aborted on that edge, with the reset values above. A new STARTCALC is accepted on the first edge after RST deasserts.
- RST has priority over STARTCALC and WE on the same edge. WE is dropped when RST=1.

## Timing
- Edge S is the edge that accepts STARTCALC.
  - BUSY=1 and RDY=0 from edge S.
  - STREAM cycle k (k=0..VECWIDTH-1) presents address k after edge S+k.
  - The accumulator holds its final sum after edge S+VECWIDTH+3.
  - SQRT occupies the cycles after edges S+VECWIDTH+4 .. S+VECWIDTH+3+OUTWIDTH.
- At edge S+VECWIDTH+OUTWIDTH+4:
  - RDY becomes 1 and OUTVAL becomes valid;
  - BUSY becomes 0;
  - the FSM is in IDLE.
- Latency is fixed at VECWIDTH+OUTWIDTH+4 edges (48 for the defaults) and is independent of the data.
- Back-to-back operation: STARTCALC held high starts the next calculation on the first edge after RDY rises. RDY is high for exactly one cycle in that case.
- Throughput: one result per VECWIDTH+OUTWIDTH+5 cycles when back-to-back.

## Test plan
1. Reset: assert RST for 2 cycles with STARTCALC=1 and WE=1 -> BUSY=0, RDY=0, OUTVAL=0; no calculation starts and no write commits.
2. A={3,4,0,...,0}, B=all 0, pulse STARTCALC -> RDY rises exactly 48 edges after acceptance; OUTVAL=5; BUSY was high for those 48 cycles.
3. Absolute difference and symmetry:
   - A=all 0, B=all 1000 -> OUTVAL=3162.
   - Swap the banks and rerun -> OUTVAL=3162.
   - A=B=arbitrary -> OUTVAL=0.
4. A={1..10}, B=all 0 -> OUTVAL=19 (sum 385, floor root).
5. Start and write guarding:
   - Pulse STARTCALC and attempt writes at edges S+5 and S+20 -> latency stays 48 and OUTVAL is unchanged by the writes.
   - A write with WADDR=12 in IDLE -> no bank changes.
6. Assert RST at edge S+30, release it, then start again with A={6,8,0,...}, B=0 -> RDY=0 and OUTVAL=0 right after reset; second run gives OUTVAL=10 after 48 edges.
